// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, word tags, stop reasons and limit helper (honours ADC_SEQ_DROP_CNT_EN)
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        END    = 3'd4
    } seq_state_e;

    localparam logic [1:0] TAG_HDR_LO = 2'b00;
    localparam logic [1:0] TAG_HDR_HI = 2'b01;
    localparam logic [1:0] TAG_DATA   = 2'b10;
    localparam logic [1:0] TAG_END    = 2'b11;

    localparam logic [1:0] RSN_LEVEL = 2'b01;
    localparam logic [1:0] RSN_LIMIT = 2'b10;
    localparam logic [1:0] RSN_STOP  = 2'b11;

    // The drop flag steals the top bit of the word count when drop counting is built in.
`ifdef ADC_SEQ_DROP_CNT_EN
    localparam int NW_W = 27;
`else
    localparam int NW_W = 28;
`endif

    // Maximum data words per burst: 2^min(lim, max_log2).
    function automatic logic [30:0] burst_limit(input logic [7:0] lim, input int unsigned max_log2);
        int unsigned sh;
        sh = (32'(lim) > max_log2) ? max_log2 : 32'(lim);
        return 31'd1 << sh;
    endfunction

endpackage

// File: rtl/adc_seq_out_reg.sv
// rtl/adc_seq_out_reg.sv - 32-bit tvalid/tready holding register with load/free handshake
module adc_seq_out_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] din,
    input  logic        tready,
    output logic        free,
    output logic        tvalid,
    output logic [31:0] tdata
);

    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;

    // The slot can take a new word when empty or when its current word is leaving this cycle.
    assign free   = !tvalid_q || tready;
    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;

    // Load replaces the word; otherwise the word holds until accepted.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = din;
        end else if (tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tvalid_q <= 1'b0;
            tdata_q  <= 32'd0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

endmodule

// File: rtl/adc_burst_sequencer.sv
// rtl/adc_burst_sequencer.sv - trigger/hysteresis burst framer onto a stream; ADC_SEQ_DROP_CNT_EN adds drop_count
module adc_burst_sequencer
    import adc_seq_pkg::*;
#(
    parameter int HOLDOFF_W = 16,
    parameter int MAX_LOG2  = 30
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        arm,
    input  logic        force_stop,
    input  logic [15:0] trigger_level,
    input  logic [15:0] hysteresis,
    input  logic [7:0]  limiter,
    input  logic [15:0] holdoff,
    input  logic        s_valid,
    input  logic [15:0] s_sum_abs,
    input  logic [14:0] s_dat_a,
    input  logic [14:0] s_dat_b,
    input  logic [63:0] timestamp,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        busy,
    output logic [15:0] bursts_count,
    output logic [1:0]  last_reason
`ifdef ADC_SEQ_DROP_CNT_EN
    ,
    output logic [31:0] drop_count
`endif
);

    seq_state_e           state_q, state_d;
    logic [59:0]          ts_q, ts_d;
    logic [NW_W-1:0]      nwords_q, nwords_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [1:0]           reason_q, reason_d;
    logic [HOLDOFF_W-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic [15:0]          bursts_q, bursts_d;
    logic [1:0]           last_reason_q, last_reason_d;
    logic                 load, out_free;
    logic [31:0]          load_word;
    logic [15:0]          close_thr;
    logic                 nwords_at_limit;
    logic                 end_accepted;
    logic                 unused_ts_hi;
`ifdef ADC_SEQ_DROP_CNT_EN
    logic [31:0]          drop_count_q, drop_count_d;
    assign drop_count = drop_count_q;
`endif

    assign unused_ts_hi    = ^timestamp[63:60];
    assign close_thr       = (trigger_level > hysteresis) ? (trigger_level - hysteresis) : 16'd0;
    assign nwords_at_limit = (31'(nwords_q) == burst_limit(limiter, MAX_LOG2));
    assign end_accepted    = m_axis_tvalid && m_axis_tready && (m_axis_tdata[31:30] == TAG_END);
    assign busy            = (state_q != IDLE);
    assign bursts_count    = bursts_q;
    assign last_reason     = last_reason_q;

    adc_seq_out_reg u_out_reg (
        .clk    (aclk),
        .resetn (aresetn),
        .load   (load),
        .din    (load_word),
        .tready (m_axis_tready),
        .free   (out_free),
        .tvalid (m_axis_tvalid),
        .tdata  (m_axis_tdata)
    );

    // Burst FSM: trigger, header emission, sample loading, stop decision and END word.
    always_comb begin
        state_d       = state_q;
        ts_d          = ts_q;
        nwords_d      = nwords_q;
        stop_pend_d   = stop_pend_q;
        reason_d      = reason_q;
        holdoff_cnt_d = holdoff_cnt_q;
        load          = 1'b0;
        load_word     = 32'd0;
`ifdef ADC_SEQ_DROP_CNT_EN
        drop_count_d  = drop_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (holdoff_cnt_q != '0) begin
                    holdoff_cnt_d = holdoff_cnt_q - HOLDOFF_W'(1);
                end
                if (arm && s_valid && (s_sum_abs > trigger_level) && (holdoff_cnt_q == '0)) begin
                    state_d     = HDR_LO;
                    ts_d        = timestamp[59:0];
                    nwords_d    = '0;
                    stop_pend_d = 1'b0;
`ifdef ADC_SEQ_DROP_CNT_EN
                    drop_count_d = 32'd0;
`endif
                end
            end
            HDR_LO: begin
                stop_pend_d = stop_pend_q || force_stop;
                if (out_free) begin
                    load      = 1'b1;
                    load_word = {TAG_HDR_LO, ts_q[29:0]};
                    state_d   = HDR_HI;
                end
            end
            HDR_HI: begin
                stop_pend_d = stop_pend_q || force_stop;
                if (out_free) begin
                    load      = 1'b1;
                    load_word = {TAG_HDR_HI, ts_q[59:30]};
                    if (stop_pend_q || force_stop) begin
                        state_d  = END;
                        reason_d = RSN_STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (force_stop || !arm) begin
                    state_d  = END;
                    reason_d = RSN_STOP;
                end else if (nwords_at_limit) begin
                    state_d  = END;
                    reason_d = RSN_LIMIT;
                end else if (s_valid && (s_sum_abs < close_thr)) begin
                    state_d  = END;
                    reason_d = RSN_LEVEL;
                end else if (s_valid) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_word = {TAG_DATA, s_dat_a, s_dat_b};
                        if (nwords_q != '1) begin
                            nwords_d = nwords_q + NW_W'(1);
                        end
`ifdef ADC_SEQ_DROP_CNT_EN
                    end else if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + 32'd1;
`endif
                    end
                end
            end
            END: begin
                if (out_free) begin
                    load          = 1'b1;
`ifdef ADC_SEQ_DROP_CNT_EN
                    load_word     = {TAG_END, (drop_count_q != 32'd0), reason_q, nwords_q};
`else
                    load_word     = {TAG_END, reason_q, nwords_q};
`endif
                    holdoff_cnt_d = HOLDOFF_W'(holdoff);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completed-burst statistics follow the END word as it leaves the stream.
    always_comb begin
        bursts_d      = bursts_q;
        last_reason_d = last_reason_q;
        if (end_accepted) begin
            bursts_d = bursts_q + 16'd1;
`ifdef ADC_SEQ_DROP_CNT_EN
            last_reason_d = m_axis_tdata[28:27];
`else
            last_reason_d = m_axis_tdata[29:28];
`endif
        end
    end

    // State registers; reset aborts any open burst.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            ts_q          <= '0;
            nwords_q      <= '0;
            stop_pend_q   <= 1'b0;
            reason_q      <= 2'b00;
            holdoff_cnt_q <= '0;
            bursts_q      <= 16'd0;
            last_reason_q <= 2'b00;
`ifdef ADC_SEQ_DROP_CNT_EN
            drop_count_q  <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_d;
            nwords_q      <= nwords_d;
            stop_pend_q   <= stop_pend_d;
            reason_q      <= reason_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            bursts_q      <= bursts_d;
            last_reason_q <= last_reason_d;
`ifdef ADC_SEQ_DROP_CNT_EN
            drop_count_q  <= drop_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// tb/tb_adc_burst_sequencer.sv - randomized scoreboard bench for adc_burst_sequencer (ADC_SEQ_DROP_CNT_EN aware)
module tb_adc_burst_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        arm;
    logic        force_stop;
    logic [15:0] trigger_level;
    logic [15:0] hysteresis;
    logic [7:0]  limiter;
    logic [15:0] holdoff;
    logic        s_valid;
    logic [15:0] s_sum_abs;
    logic [14:0] s_dat_a;
    logic [14:0] s_dat_b;
    logic [63:0] timestamp;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        busy;
    logic [15:0] bursts_count;
    logic [1:0]  last_reason;
`ifdef ADC_SEQ_DROP_CNT_EN
    logic [31:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;

    adc_burst_sequencer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .arm           (arm),
        .force_stop    (force_stop),
        .trigger_level (trigger_level),
        .hysteresis    (hysteresis),
        .limiter       (limiter),
        .holdoff       (holdoff),
        .s_valid       (s_valid),
        .s_sum_abs     (s_sum_abs),
        .s_dat_a       (s_dat_a),
        .s_dat_b       (s_dat_b),
        .timestamp     (timestamp),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .busy          (busy),
        .bursts_count  (bursts_count),
        .last_reason   (last_reason)
`ifdef ADC_SEQ_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (burst phases in plain integers) ----------------
    localparam int P_IDLE = 0, P_HLO = 1, P_HHI = 2, P_DATA = 3, P_END = 4;

    logic [31:0]     exp_q[$];
    int              m_phase   = P_IDLE;
    longint unsigned m_ts      = 0;
    longint          m_nw      = 0;
    bit              m_stop    = 0;
    int              m_reason  = 0;
    int              m_hold    = 0;
    bit              m_occ     = 0;
    logic [31:0]     m_word    = 0;
    int              m_bursts  = 0;
    int              m_lastrsn = 0;
    longint          m_drops   = 0;

    function automatic logic [31:0] end_word(input int rsn, input longint nw, input longint drops);
`ifdef ADC_SEQ_DROP_CNT_EN
        return 32'hC000_0000 | ((drops > 0) ? 32'h2000_0000 : 32'd0) | (32'(rsn) << 27) | 32'(nw % (64'd1 << 27));
`else
        if (drops < 0) return 32'd0;
        return 32'hC000_0000 | (32'(rsn) << 28) | 32'(nw % (64'd1 << 28));
`endif
    endfunction

    // Model advances at the falling edge on the inputs the DUT will see at the next rising edge.
    initial forever begin
        @(negedge aclk);
        check("tvalid", longint'(m_axis_tvalid), longint'(m_occ));
        check("busy", longint'(busy), longint'(m_phase != P_IDLE));
        check("bursts_count", longint'(bursts_count), longint'(m_bursts % 65536));
        check("last_reason", longint'(last_reason), longint'(m_lastrsn));
`ifdef ADC_SEQ_DROP_CNT_EN
        check("drop_count", longint'(drop_count), m_drops);
`endif
        if (!aresetn) begin
            m_phase = P_IDLE; m_ts = 0; m_nw = 0; m_stop = 0; m_reason = 0; m_hold = 0;
            m_occ = 0; m_word = 0; m_bursts = 0; m_lastrsn = 0; m_drops = 0;
            exp_q.delete();
        end else begin
            automatic bit          accept = m_occ && m_axis_tready;
            automatic bit          free   = !m_occ || m_axis_tready;
            automatic bit          ld     = 0;
            automatic logic [31:0] w      = 0;
            automatic int          cl     = (trigger_level > hysteresis) ? int'(trigger_level) - int'(hysteresis) : 0;
            automatic longint      lim    = longint'(1) << ((limiter > 30) ? 30 : int'(limiter));
            if (accept && (m_word >> 30) == 3) begin
                m_bursts++;
`ifdef ADC_SEQ_DROP_CNT_EN
                m_lastrsn = int'((m_word >> 27) & 3);
`else
                m_lastrsn = int'((m_word >> 28) & 3);
`endif
            end
            case (m_phase)
                P_IDLE: begin
                    if (arm && s_valid && s_sum_abs > trigger_level && m_hold == 0) begin
                        m_phase = P_HLO; m_ts = timestamp; m_nw = 0; m_stop = 0; m_drops = 0;
                    end
                    if (m_hold > 0) m_hold--;
                end
                P_HLO: begin
                    m_stop = m_stop || force_stop;
                    if (free) begin ld = 1; w = 32'(m_ts % (64'd1 << 30)); m_phase = P_HHI; end
                end
                P_HHI: begin
                    m_stop = m_stop || force_stop;
                    if (free) begin
                        ld = 1; w = 32'h4000_0000 | 32'((m_ts >> 30) % (64'd1 << 30));
                        if (m_stop) begin m_phase = P_END; m_reason = 3; end
                        else m_phase = P_DATA;
                    end
                end
                P_DATA: begin
                    if (force_stop || !arm) begin m_phase = P_END; m_reason = 3; end
                    else if (m_nw == lim) begin m_phase = P_END; m_reason = 2; end
                    else if (s_valid && int'(s_sum_abs) < cl) begin m_phase = P_END; m_reason = 1; end
                    else if (s_valid) begin
                        if (free) begin
                            ld = 1; w = 32'h8000_0000 | (32'(s_dat_a) << 15) | 32'(s_dat_b);
                            m_nw++;
                        end else m_drops++;
                    end
                end
                default: begin
                    if (free) begin
                        ld = 1; w = end_word(m_reason, m_nw, m_drops);
                        m_hold = int'(holdoff); m_phase = P_IDLE;
                    end
                end
            endcase
            if (ld) begin m_occ = 1; m_word = w; exp_q.push_back(w); end
            else if (accept) m_occ = 0;
        end
    end

    // ---------------- monitor: compares every accepted word with the scoreboard ----------------
    initial forever begin
        @(negedge aclk);
        if (aresetn && m_axis_tvalid === 1'b1 && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", longint'(m_axis_tdata), -1);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                check("tdata", longint'(m_axis_tdata), longint'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int sum, input bit fs, input bit rdy);
        @(posedge aclk);
        #2;
        s_valid       = v;
        s_sum_abs     = 16'(sum);
        force_stop    = fs;
        m_axis_tready = rdy;
        s_dat_a       = 15'($urandom);
        s_dat_b       = 15'($urandom);
        timestamp     = timestamp + 64'd1;
    endtask

    initial begin
        aresetn = 1'b0; arm = 1'b0; force_stop = 1'b0;
        trigger_level = 16'd100; hysteresis = 16'd20; limiter = 8'd8; holdoff = 16'd0;
        s_valid = 1'b0; s_sum_abs = 16'd0; s_dat_a = '0; s_dat_b = '0;
        timestamp = 64'h0ABC_DEF1_2345_6789;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(negedge aclk);
        check("reset_tvalid", longint'(m_axis_tvalid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_bursts", longint'(bursts_count), 0);
        check("reset_last_reason", longint'(last_reason), 0);

        // Level-closed burst of five samples.
        arm = 1'b1;
        repeat (5) drive(1, 150, 0, 1);
        drive(1, 70, 0, 1);
        repeat (8) drive(0, 0, 0, 1);
        // Limit-closed burst with holdoff, then a stall mid-DATA.
        limiter = 8'd2; holdoff = 16'd10;
        repeat (20) drive(1, 150, 0, 1);
        limiter = 8'd5; holdoff = 16'd0;
        repeat (4) drive(1, 150, 0, 1);
        repeat (3) drive(1, 150, 0, 0);
        drive(1, 10, 0, 1);
        repeat (6) drive(0, 0, 0, 1);
        // force_stop during HDR_LO.
        drive(1, 150, 0, 0);
        drive(0, 0, 1, 0);
        repeat (6) drive(0, 0, 0, 1);
        // Close threshold saturates at 0: only limit ends the burst.
        hysteresis = 16'd200; limiter = 8'd0;
        drive(1, 150, 0, 1);
        repeat (4) drive(1, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 1);

        for (int seg = 0; seg < 24; seg++) begin
            automatic int rdy_pct = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 70 : 40);
            trigger_level = 16'($urandom_range(50, 300));
            hysteresis    = ($urandom_range(0, 4) == 0) ? trigger_level + 16'd10 : 16'($urandom_range(0, 60));
            limiter       = (seg % 6 == 5) ? 8'd8 : 8'($urandom_range(0, 5));
            holdoff       = 16'($urandom_range(0, 15));
            for (int c = 0; c < 300; c++) begin
                arm     = ($urandom_range(0, 199) != 0);
                aresetn = !(seg == 12 && c == 150);
                drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 400)),
                      $urandom_range(0, 99) == 0, int'($urandom_range(1, 100)) <= rdy_pct);
            end
        end
        aresetn = 1'b1; arm = 1'b0;
        repeat (40) drive(0, 0, 0, 1);
        @(negedge aclk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        check("final_bursts", longint'(bursts_count), longint'(m_bursts % 65536));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
